// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the integer register file.
//   REG_BUS_W / REG_ADDR_W / REG_NUM : default data width, address width, entry count
//   ZERO_WORD / NOP_REG_ADDR         : value of r0 and its address
//   WRITE_ENABLE / READ_ENABLE       : active levels of the enable strobes
//   rsrc_e                           : read-port data source after priority decode
package regfile_pkg;

  localparam int          REG_BUS_W    = 32;
  localparam int          REG_ADDR_W   = 5;
  localparam int          REG_NUM      = 32;
  localparam int          NUM_RPORTS   = 2;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic        READ_ENABLE  = 1'b1;

  typedef enum logic [1:0] {
    RSRC_ZERO   = 2'd0,
    RSRC_BYPASS = 2'd1,
    RSRC_ARRAY  = 2'd2
  } rsrc_e;

endpackage

// File: rtl/regfile_rport.sv
// regfile_rport: one combinational read port of the register file.
//   rst    in  async reset level (0 = in reset), forces output to zero
//   re     in  read enable
//   raddr  in  read address
//   we     in  write enable of the write-back port (for bypass)
//   waddr  in  write address of the write-back port
//   wdata  in  write data of the write-back port
//   entry  in  stored array value at raddr
//   rdata  out selected read data
module regfile_rport
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] entry,
  output logic [DATA_W-1:0] rdata
);

  rsrc_e src;

  // Priority: reset, disabled port, r0, same-cycle write, stored value.
  // r0 is tested before bypass so a discarded write to r0 never leaks out.
  always_comb begin
    src = RSRC_ARRAY;
    if (!rst)                                              src = RSRC_ZERO;
    else if (re != READ_ENABLE)                            src = RSRC_ZERO;
    else if (raddr == '0)                                  src = RSRC_ZERO;
    else if (BYPASS && we == WRITE_ENABLE && waddr == raddr) src = RSRC_BYPASS;
  end

  always_comb begin
    rdata = '0;
    unique case (src)
      RSRC_BYPASS: rdata = wdata;
      RSRC_ARRAY:  rdata = entry;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: rtl/regfile.sv
// regfile: integer register file at the write-back end of the pipeline.
//   clk            in  rising-edge clock
//   rst            in  async active-low reset; clears all entries, zeroes reads
//   we/waddr/wdata in  write-back triple; writes to r0 are discarded
//   re1/raddr1     in  read port 1 enable/address
//   rdata1         out read port 1 data (combinational)
//   re2/raddr2     in  read port 2 enable/address
//   rdata2         out read port 2 data (combinational)
// With BYPASS=1 a read of the register being written returns wdata in the
// same cycle, so ID sees the WB result without waiting for the edge.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = REG_NUM,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic              wr_en_d;

  // r0 is hardwired; never let a write land there.
  assign wr_en_d = (we == WRITE_ENABLE) && (waddr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_d) begin
      mem_q[waddr] <= wdata;
    end
  end

  logic [NUM_RPORTS-1:0]             re_v;
  logic [NUM_RPORTS-1:0][ADDR_W-1:0] raddr_v;
  logic [NUM_RPORTS-1:0][DATA_W-1:0] rdata_v;

  assign re_v    = {re2, re1};
  assign raddr_v = {raddr2, raddr1};

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    regfile_rport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_rport (
      .rst   (rst),
      .re    (re_v[p]),
      .raddr (raddr_v[p]),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .entry (mem_q[raddr_v[p]]),
      .rdata (rdata_v[p])
    );
  end

  assign rdata1 = rdata_v[0];
  assign rdata2 = rdata_v[1];

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: self-checking bench for regfile. Two instances share stimulus:
// u_dut (BYPASS=1) and u_nb (BYPASS=0). Directed vectors come from a table,
// reset corner cases are hand sequenced, and a random phase is checked
// against an array-based reference model.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;

  int checks   = 0;
  int failures = 0;

  regfile #(.BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );

  regfile #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(nb_rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(nb_rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] exp1, exp2;       // BYPASS=1 instance
    logic [31:0] exp1_nb, exp2_nb; // BYPASS=0 instance
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
  endtask

  // Reference model: plain storage array plus the read rules.
  logic [31:0] ref_mem [32];

  function automatic logic [31:0] ref_read(input logic r, input logic e, input logic [4:0] a, input bit byp);
    if (!r || !e || a == 5'd0) return 32'h0;
    if (byp && we && waddr == a) return wdata;
    return ref_mem[a];
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
  endtask

  vec_t vecs [9];

  initial begin
    // Directed table; entries are applied one per cycle with state carried over.
    //         rst we wa     wdata          re1 a1     re2 a2     exp1           exp2           exp1_nb        exp2_nb
    vecs[0] = '{1, 1, 5'd7,  32'hDEADBEEF, 0, 5'd7,  0, 5'd7,  32'h0,         32'h0,         32'h0,         32'h0};
    vecs[1] = '{1, 0, 5'd0,  32'h0,        1, 5'd7,  0, 5'd7,  32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  32'h0};
    vecs[2] = '{1, 1, 5'd0,  32'h12345678, 1, 5'd0,  1, 5'd7,  32'h0,         32'hDEADBEEF,  32'h0,         32'hDEADBEEF};
    vecs[3] = '{1, 0, 5'd0,  32'h0,        1, 5'd0,  1, 5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
    vecs[4] = '{1, 1, 5'd3,  32'h00001111, 1, 5'd3,  1, 5'd3,  32'h00001111,  32'h00001111,  32'h0,         32'h0};
    vecs[5] = '{1, 1, 5'd3,  32'h00002222, 1, 5'd3,  1, 5'd3,  32'h00002222,  32'h00002222,  32'h00001111,  32'h00001111};
    vecs[6] = '{1, 0, 5'd3,  32'h0,        1, 5'd3,  1, 5'd3,  32'h00002222,  32'h00002222,  32'h00002222,  32'h00002222};
    vecs[7] = '{1, 1, 5'd10, 32'hA5A5A5A5, 1, 5'd7,  1, 5'd3,  32'hDEADBEEF,  32'h00002222,  32'hDEADBEEF,  32'h00002222};
    vecs[8] = '{1, 0, 5'd0,  32'h0,        1, 5'd10, 1, 5'd31, 32'hA5A5A5A5,  32'h0,         32'hA5A5A5A5,  32'h0};

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    // Reset held: reads forced to zero even with both ports enabled.
    drive(0, 0, 0, 0, 1, 5'd5, 1, 5'd31);
    #1;
    chk("rst_hold_rd1", rdata1, 32'h0);
    chk("rst_hold_rd2", rdata2, 32'h0);
    chk("rst_hold_nb_rd1", nb_rdata1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    // All 32 registers read back zero after reset.
    for (int a = 0; a < 32; a += 2) begin
      drive(1, 0, 0, 0, 1, 5'(a), 1, 5'(a + 1));
      #1;
      chk($sformatf("post_rst_r%0d", a), rdata1, 32'h0);
      chk($sformatf("post_rst_r%0d", a + 1), rdata2, 32'h0);
      @(negedge clk);
    end

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
            vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
      #1;
      chk($sformatf("vec%0d_rd1", i), rdata1, vecs[i].exp1);
      chk($sformatf("vec%0d_rd2", i), rdata2, vecs[i].exp2);
      chk($sformatf("vec%0d_nb_rd1", i), nb_rdata1, vecs[i].exp1_nb);
      chk($sformatf("vec%0d_nb_rd2", i), nb_rdata2, vecs[i].exp2_nb);
      @(negedge clk);
    end

    // Mid-cycle reset: r10 holds A5A5A5A5 from the table.
    drive(1, 0, 0, 0, 1, 5'd10, 1, 5'd7);
    #1;
    chk("midrst_pre_r10", rdata1, 32'hA5A5A5A5);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_now_rd1", rdata1, 32'h0);
    chk("midrst_now_rd2", rdata2, 32'h0);
    // Write attempted on an edge while in reset must be lost.
    we = 1'b1; waddr = 5'd10; wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 5'd10, 1, 5'd7);
    #1;
    chk("midrst_after_r10", rdata1, 32'h0);
    chk("midrst_after_r7", rdata2, 32'h0);
    // First write after release is accepted at the first edge.
    drive(1, 1, 5'd10, 32'hCAFE0001, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 5'd10, 0, 0);
    #1;
    chk("first_wr_after_rst", nb_rdata1, 32'hCAFE0001);
    @(negedge clk);

    // Random phase against the reference model.
    ref_clear();
    ref_mem[10] = 32'hCAFE0001;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic        r;
      logic [4:0]  wa, a1, a2;
      r  = ($urandom_range(0, 127) != 0);
      wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      drive(r, 1'($urandom), wa, $urandom, ($urandom_range(0, 7) != 0), a1,
            ($urandom_range(0, 7) != 0), a2);
      if (!r) ref_clear();
      #1;
      if ($isunknown({rdata1, rdata2, nb_rdata1, nb_rdata2})) begin
        checks++;
        failures++;
        $display("FAIL rand_x: cycle %0d outputs %h %h %h %h required defined", cyc,
                 rdata1, rdata2, nb_rdata1, nb_rdata2);
      end
      chk("rand_rd1", rdata1, ref_read(rst, re1, raddr1, 1'b1));
      chk("rand_rd2", rdata2, ref_read(rst, re2, raddr2, 1'b1));
      chk("rand_nb_rd1", nb_rdata1, ref_read(rst, re1, raddr1, 1'b0));
      chk("rand_nb_rd2", nb_rdata2, ref_read(rst, re2, raddr2, 1'b0));
      @(posedge clk);
      if (rst && we && waddr != 5'd0) ref_mem[waddr] = wdata;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
